id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the 5-stage pipeline. It sits directly upstream of the 32-bit ALU: it captures decoded instruction fields from ID and presents forwarded operands `ex_a`/`ex_b` plus the 3-bit ALU mode `ex_m` to the ALU in EX. It supports stall (hold with operand refresh), flush (bubble insertion) and two-level forwarding from EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/id_ex_stage_if.sv | 60 ++++++
 rtl/id_ex_stage_fwd_unit.sv | 44 ++++
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage and its forwarding logic.
//   - ALU mode encodings consumed by the EX-stage ALU
//   - forward-select encodings reported on fwd_a / fwd_b
//   - default datapath and register-address widths
package pipe_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RA_DEF    = 5;

    typedef enum logic [2:0] {
        M_OR   = 3'b000,
        M_AND  = 3'b001,
        M_XOR  = 3'b010,
        M_ADD  = 3'b011,
        M_NOR  = 3'b100,
        M_NAND = 3'b101,
        M_SLT  = 3'b110,
        M_SUB  = 3'b111
    } alu_mode_e;

    localparam logic [1:0] FWD_NONE  = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every non-clock signal of the ID/EX stage.
//   ID side      : in_valid, in_rs1/rs2/rd, in_rs1_data/rs2_data, in_imm,
//                  in_use_imm, in_alu_m, in_reg_write
//   control      : stall, flush
//   forward srcs : exmem_reg_write/rd/result, memwb_reg_write/rd/result
//   EX side      : ex_valid, ex_a, ex_b, ex_m, ex_rd, ex_reg_write, fwd_a, fwd_b
// The stage itself connects through the slave modport; whoever drives the
// ID and forward inputs (and reads EX) uses master.
// Flow control: there is no valid/ready pair. A transfer from ID into EX
// happens on every rising edge where stall = 0 and flush = 0; in_valid only
// marks whether that slot carries a real instruction.
interface id_ex_stage_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA    = RA_DEF
);
    logic             in_valid;
    logic [RA-1:0]    in_rs1;
    logic [RA-1:0]    in_rs2;
    logic [RA-1:0]    in_rd;
    logic [WIDTH-1:0] in_rs1_data;
    logic [WIDTH-1:0] in_rs2_data;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [2:0]       in_alu_m;
    logic             in_reg_write;
    logic             stall;
    logic             flush;
    logic             exmem_reg_write;
    logic [RA-1:0]    exmem_rd;
    logic [WIDTH-1:0] exmem_result;
    logic             memwb_reg_write;
    logic [RA-1:0]    memwb_rd;
    logic [WIDTH-1:0] memwb_result;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [2:0]       ex_m;
    logic [RA-1:0]    ex_rd;
    logic             ex_reg_write;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_m, in_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_a, ex_b, ex_m, ex_rd, ex_reg_write, fwd_a, fwd_b
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_alu_m, in_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_a, ex_b, ex_m, ex_rd, ex_reg_write, fwd_a, fwd_b
    );
endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one source register.
//   valid           : EX slot holds a real instruction (no forwarding otherwise)
//   src, data       : registered source register number and its register-file data
//   exmem_*/memwb_* : the two forward sources (write enable, rd, result)
//   fwd_data        : operand after forwarding
//   sel             : FWD_NONE / FWD_EXMEM / FWD_MEMWB
// EX/MEM is the younger result, so it wins when both sources hit.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA    = RA_DEF
) (
    input  logic             valid,
    input  logic [RA-1:0]    src,
    input  logic [WIDTH-1:0] data,
    input  logic             exmem_reg_write,
    input  logic [RA-1:0]    exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA-1:0]    memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] fwd_data,
    output logic [1:0]       sel
);
    logic exmem_hit;
    logic memwb_hit;

    // A zero rd never matches, so register 0 is never forwarded.
    assign exmem_hit = valid && exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
    assign memwb_hit = valid && memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

    always_comb begin
        fwd_data = data;
        sel      = FWD_NONE;
        if (exmem_hit) begin
            fwd_data = exmem_result;
            sel      = FWD_EXMEM;
        end else if (memwb_hit) begin
            fwd_data = memwb_result;
            sel      = FWD_MEMWB;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with two-level operand forwarding in front of the ALU.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : id_ex_stage_if.slave -- ID fields, stall/flush, forward sources in;
//           forwarded operands, ALU mode, destination and forward selects out
// Edge priority is flush > stall > advance. During a stall the operand data
// registers re-capture the forwarded values, so a forward source that moves
// on while EX is held does not take its result with it.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA    = RA_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic             valid_q;
    logic [RA-1:0]    rs1_q;
    logic [RA-1:0]    rs2_q;
    logic [RA-1:0]    rd_q;
    logic [WIDTH-1:0] rs1_data_q;
    logic [WIDTH-1:0] rs2_data_q;
    logic [WIDTH-1:0] imm_q;
    logic             use_imm_q;
    logic [2:0]       m_q;
    logic             reg_write_q;

    logic [WIDTH-1:0] fwd_data_a;
    logic [WIDTH-1:0] fwd_data_b;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            m_q         <= 3'b000;
            reg_write_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (bus.stall) begin
            // fwd_data_b is the forwarded rs2 even when B uses the immediate.
            rs1_data_q  <= fwd_data_a;
            rs2_data_q  <= fwd_data_b;
        end else begin
            valid_q     <= bus.in_valid;
            rs1_q       <= bus.in_rs1;
            rs2_q       <= bus.in_rs2;
            rd_q        <= bus.in_rd;
            rs1_data_q  <= bus.in_rs1_data;
            rs2_data_q  <= bus.in_rs2_data;
            imm_q       <= bus.in_imm;
            use_imm_q   <= bus.in_use_imm;
            m_q         <= bus.in_alu_m;
            reg_write_q <= bus.in_reg_write & bus.in_valid;
        end
    end

    fwd_unit #(.WIDTH(WIDTH), .RA(RA)) u_fwd_a (
        .valid           (valid_q),
        .src             (rs1_q),
        .data            (rs1_data_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_data_a),
        .sel             (sel_a)
    );

    fwd_unit #(.WIDTH(WIDTH), .RA(RA)) u_fwd_b (
        .valid           (valid_q),
        .src             (rs2_q),
        .data            (rs2_data_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_data_b),
        .sel             (sel_b)
    );

    assign bus.ex_valid     = valid_q;
    assign bus.ex_a         = fwd_data_a;
    assign bus.ex_b         = use_imm_q ? imm_q : fwd_data_b;
    assign bus.ex_m         = m_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = reg_write_q & valid_q;
    assign bus.fwd_a        = sel_a;
    assign bus.fwd_b        = use_imm_q ? FWD_NONE : sel_b;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Contents of the EX slot as the specification describes it.
    logic        r_valid;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_d1;
    logic [31:0] r_d2;
    logic [31:0] r_imm;
    logic        r_use_imm;
    logic [2:0]  r_m;
    logic        r_rw;

    task automatic model_reset();
        r_valid = 0; r_rs1 = 0; r_rs2 = 0; r_rd = 0; r_d1 = 0; r_d2 = 0;
        r_imm = 0; r_use_imm = 0; r_m = 0; r_rw = 0;
    endtask

    // Which result the EX operand for register src should see right now:
    // returns {select, value}.
    function automatic logic [33:0] ref_fwd(input logic [4:0] src, input logic [31:0] data);
        if (r_valid && src != 0) begin
            if (bus.exmem_reg_write && bus.exmem_rd == src) return {2'd1, bus.exmem_result};
            if (bus.memwb_reg_write && bus.memwb_rd == src) return {2'd2, bus.memwb_result};
        end
        return {2'd0, data};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs(input string tag);
        logic [33:0] fa;
        logic [33:0] fb;
        fa = ref_fwd(r_rs1, r_d1);
        fb = ref_fwd(r_rs2, r_d2);
        check({tag, ".valid"}, 32'(bus.ex_valid), 32'(r_valid));
        check({tag, ".a"},     bus.ex_a, fa[31:0]);
        check({tag, ".b"},     bus.ex_b, r_use_imm ? r_imm : fb[31:0]);
        check({tag, ".m"},     32'(bus.ex_m), 32'(r_m));
        check({tag, ".rw"},    32'(bus.ex_reg_write), 32'(r_rw && r_valid));
        check({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'(fa[33:32]));
        check({tag, ".fwd_b"}, 32'(bus.fwd_b), r_use_imm ? 32'd0 : 32'(fb[33:32]));
        if (r_valid) check({tag, ".rd"}, 32'(bus.ex_rd), 32'(r_rd));
    endtask

    // ---------------- driver ----------------
    // One clock: the model decides the next slot contents from the inputs
    // present before the edge, then both are compared just after it.
    task automatic step(input string tag);
        logic [33:0] fa;
        logic [33:0] fb;
        fa = ref_fwd(r_rs1, r_d1);
        fb = ref_fwd(r_rs2, r_d2);
        @(posedge clk);
        if (bus.flush) begin
            r_valid = 0;
            r_rw    = 0;
        end else if (bus.stall) begin
            r_d1 = fa[31:0];
            r_d2 = fb[31:0];
        end else begin
            r_valid   = bus.in_valid;
            r_rs1     = bus.in_rs1;
            r_rs2     = bus.in_rs2;
            r_rd      = bus.in_rd;
            r_d1      = bus.in_rs1_data;
            r_d2      = bus.in_rs2_data;
            r_imm     = bus.in_imm;
            r_use_imm = bus.in_use_imm;
            r_m       = bus.in_alu_m;
            r_rw      = bus.in_reg_write && bus.in_valid;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic use_imm, input logic [2:0] m,
                             input logic rw);
        bus.in_valid = v; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
        bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm;
        bus.in_use_imm = use_imm; bus.in_alu_m = m; bus.in_reg_write = rw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    task automatic random_fwd();
        set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.stall = 0;
        bus.flush = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Advance: 5 SUB 3 into r4.
        set_instr(1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd3, 32'd0, 0, 3'b111, 1);
        step("adv");
        check("adv.a_const", bus.ex_a, 32'd5);
        check("adv.b_const", bus.ex_b, 32'd3);
        check("adv.m_const", 32'(bus.ex_m), 32'd7);

        // Forward priority on rs1 = 7.
        set_instr(1, 5'd7, 5'd2, 5'd8, 32'h11, 32'h22, 32'd0, 0, 3'b011, 1);
        set_fwd(1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
        step("prio");
        check("prio.a_const", bus.ex_a, 32'hAA);
        check("prio.fwd_a_const", 32'(bus.fwd_a), 32'd1);
        bus.exmem_reg_write = 0;
        #1;
        check_outputs("prio_memwb");
        check("prio_memwb.a_const", bus.ex_a, 32'hBB);
        check("prio_memwb.fwd_a_const", 32'(bus.fwd_a), 32'd2);

        // Register 0 is never forwarded.
        set_instr(1, 5'd0, 5'd2, 5'd8, 32'h33, 32'h22, 32'd0, 0, 3'b000, 1);
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        step("r0");
        check("r0.a_const", bus.ex_a, 32'h33);
        check("r0.fwd_a_const", 32'(bus.fwd_a), 32'd0);

        // Stall refresh: EX/MEM forwards 0x1234 to rs2 = 9, then moves on.
        set_instr(1, 5'd1, 5'd9, 5'd5, 32'h1, 32'h55, 32'd0, 0, 3'b010, 1);
        set_fwd(1, 5'd9, 32'h1234, 0, 5'd0, 32'd0);
        step("pre_stall");
        check("pre_stall.b_const", bus.ex_b, 32'h1234);
        bus.stall = 1;
        set_instr(1, 5'd3, 5'd3, 5'd3, 32'hDEAD, 32'hBEEF, 32'd0, 0, 3'b001, 1);
        step("stall1");
        bus.exmem_rd = 5'd10;
        #1;
        check_outputs("stall_moved");
        check("stall_moved.b_const", bus.ex_b, 32'h1234);
        check("stall_moved.fwd_b_const", 32'(bus.fwd_b), 32'd0);
        step("stall2");

        // Flush and stall together: flush wins.
        bus.flush = 1;
        step("flush_stall");
        check("flush_stall.valid_const", 32'(bus.ex_valid), 32'd0);
        check("flush_stall.rw_const", 32'(bus.ex_reg_write), 32'd0);
        bus.flush = 0;
        bus.stall = 0;

        // Immediate operand overrides an rs2 forward hit.
        set_instr(1, 5'd1, 5'd3, 5'd6, 32'h7, 32'h8, 32'hFFFF_FFFF, 1, 3'b011, 1);
        set_fwd(1, 5'd3, 32'h4444, 0, 5'd0, 32'd0);
        step("imm");
        check("imm.b_const", bus.ex_b, 32'hFFFF_FFFF);
        check("imm.fwd_b_const", 32'(bus.fwd_b), 32'd0);

        // Bubble on advance: in_valid = 0 kills reg_write.
        set_instr(0, 5'd1, 5'd2, 5'd6, 32'h7, 32'h8, 32'd0, 0, 3'b011, 1);
        step("bubble");
        check("bubble.rw_const", 32'(bus.ex_reg_write), 32'd0);

        // Reset during a stall clears immediately; first edge after is an advance.
        set_instr(1, 5'd2, 5'd3, 5'd9, 32'h99, 32'h77, 32'd0, 0, 3'b110, 1);
        step("pre_rst");
        bus.stall = 1;
        step("rst_stall");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 0;
        set_instr(1, 5'd2, 5'd3, 5'd9, 32'h66, 32'h77, 32'd0, 0, 3'b100, 1);
        set_fwd(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step("post_rst");

        // Randomized traffic with small register numbers so forwards hit often.
        for (int i = 0; i < 400; i++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            set_instr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                      $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            random_fwd();
            step("rand");
            random_fwd();
            #1;
            check_outputs("rand_comb");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
